// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// The FSM encoding and the counter sizing used by the top level are defined here.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width for a WIDTH-bit word; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit loadable shift register feeding the serial output.
// Priority is clear > load > shift; vacated positions fill with zero.
module piso_shift_reg
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic             sout
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        // NOTE: default first so every path assigns shreg_d and no latch is inferred.
        shreg_d = shreg_q;
        if (clear) begin
            shreg_d = '0;
        end else if (load) begin
            shreg_d = d;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (!reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Serializer top: IDLE/SHIFT handshake FSM, bit counter and done flag
// around a loadable shift register.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          done_q;
    logic          done_d;
    logic          load;
    logic          xfer;
    logic          shreg_bit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        xfer    = 1'b0;
        // Abort wins over both capture and transfer.
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        load    = 1'b1;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        xfer = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .load     (load),
        .shift_en (xfer),
        .d        (d),
        .sout     (shreg_bit)
    );

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == SHIFT);
    assign sout_valid = busy;
    assign sout       = busy & shreg_bit;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first serializer share one
// stimulus stream and are compared against per-instance expected-bit queues.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         clear;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] d;

    logic m_in_ready, m_sout, m_sout_valid, m_busy, m_done;
    logic l_in_ready, l_sout, l_sout_valid, l_busy, l_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bits still owed by each instance, head = current sout.
    bit qm[$];
    bit ql[$];
    bit exp_done;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .d          (d),
        .in_ready   (m_in_ready),
        .sout       (m_sout),
        .sout_valid (m_sout_valid),
        .out_ready  (out_ready),
        .busy       (m_busy),
        .done       (m_done)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .d          (d),
        .in_ready   (l_in_ready),
        .sout       (l_sout),
        .sout_valid (l_sout_valid),
        .out_ready  (out_ready),
        .busy       (l_busy),
        .done       (l_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit mb;
        bit lb;
        mb = (qm.size() != 0);
        lb = (ql.size() != 0);
        check("msb in_ready",   m_in_ready,   !mb);
        check("msb busy",       m_busy,       mb);
        check("msb sout_valid", m_sout_valid, mb);
        check("msb sout",       m_sout,       mb ? qm[0] : 1'b0);
        check("msb done",       m_done,       exp_done);
        check("lsb in_ready",   l_in_ready,   !lb);
        check("lsb busy",       l_busy,       lb);
        check("lsb sout_valid", l_sout_valid, lb);
        check("lsb sout",       l_sout,       lb ? ql[0] : 1'b0);
        check("lsb done",       l_done,       exp_done);
    endtask

    task automatic model_reset();
        qm.delete();
        ql.delete();
        exp_done = 1'b0;
    endtask

    // Check current outputs, advance the model with the driven inputs, then clock.
    task automatic step();
        bit busy_now;
        bit nd;
        check_outputs();
        busy_now = (qm.size() != 0);
        nd = 1'b0;
        if (clear) begin
            qm.delete();
            ql.delete();
        end else if (!busy_now && in_valid) begin
            for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
            for (int i = 0; i < W; i++)      ql.push_back(d[i]);
        end else if (busy_now && out_ready) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
            nd = (qm.size() == 0);
        end
        exp_done = nd;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] dd, input logic ord, input logic clr);
        in_valid  = iv;
        d         = dd;
        out_ready = ord;
        clear     = clr;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            step();
            n++;
        end
        check("drain bound", m_busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit a5_bits[8];
        bit lsb01_bits[8];
        int shift_cycles;

        a5_bits    = '{1, 0, 1, 0, 0, 1, 0, 1};
        lsb01_bits = '{1, 0, 0, 0, 0, 0, 0, 0};

        // Reset held for two cycles.
        reset = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b1;
        step();

        // MSB-first 8'hA5, explicit bit sequence, then done with in_ready.
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("a5 bit", m_sout, a5_bits[i]);
            step();
        end
        check("a5 done", m_done, 1'b1);
        check("a5 in_ready at done", m_in_ready, 1'b1);
        step();
        check("a5 done one cycle", m_done, 1'b0);

        // 8'hC3 with a three-cycle stall after the second bit.
        drive(1'b1, 8'hC3, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        shift_cycles = 0;
        while (m_busy && shift_cycles < 40) begin
            out_ready = !(shift_cycles >= 2 && shift_cycles <= 4);
            if (!out_ready) check("c3 stall sout", m_sout, 1'b0);
            shift_cycles++;
            step();
        end
        check("c3 shift cycles", shift_cycles, 11);
        out_ready = 1'b1;
        step();

        // Load attempts during SHIFT ignored; next word offered in the done cycle.
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        drain(20);
        check("b2b done", m_done, 1'b1);
        drive(1'b1, 8'h0F, 1'b1, 1'b0);
        step();
        check("b2b accepted", m_busy, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drain(20);
        step();

        // Clear after three bits, together with in_valid.
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) step();
        drive(1'b1, 8'h5A, 1'b1, 1'b1);
        step();
        check("clear in_ready", m_in_ready, 1'b1);
        check("clear no capture", m_busy, 1'b0);
        check("clear no done", m_done, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();

        // LSB-first 8'h01 on the second instance.
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("lsb01 bit", l_sout, lsb01_bits[i]);
            step();
        end
        check("lsb01 done", l_done, 1'b1);
        step();

        // Reset asserted mid-word: outputs return to reset values before the next edge.
        drive(1'b1, 8'hE7, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        check("midrst in_ready", m_in_ready, 1'b1);
        check("midrst busy", m_busy, 1'b0);
        check("midrst sout_valid", m_sout_valid, 1'b0);
        check("midrst sout", m_sout, 1'b0);
        check("midrst done", m_done, 1'b0);
        check("midrst lsb busy", l_busy, 1'b0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                  W'($urandom),
                  ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage that takes a WIDTH-bit word from a loadable register stage and shifts it out one bit per accepted cycle. It sits directly downstream of the loadable flip-flop register bank and consumes its parallel q outputs. Both sides use a valid/ready handshake. A one-cycle done pulse marks the end of each word.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 leaves first; 0 = bit 0 leaves first.

Ports:
clock  input  1  single system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; clears all state immediately when 0.
clear  input  1  synchronous abort; discards the word in flight.
in_valid  input  1  upstream presents a word on d.
d  input  WIDTH  parallel word from the register stage.
in_ready  output  1  serializer can accept a word.
sout  output  1  current serial bit.
sout_valid  output  1  sout holds a valid bit.
out_ready  input  1  downstream accepts sout this cycle.
busy  output  1  a word is in flight.
done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, counter=0, in_ready=1, sout=0, sout_valid=0, busy=0, done=0.
- States: IDLE and SHIFT. done is a registered flag, not a state.
- IDLE:
  - in_ready=1, sout_valid=0, sout=0.
  - When in_valid=1: capture d into the shift register, set counter=WIDTH-1, go to SHIFT on the next edge.
- SHIFT:
  - in_ready=0, busy=1, sout_valid=1.
  - sout = shreg[WIDTH-1] if MSB_FIRST=1, else shreg[0].
  - Bit transfer happens when sout_valid=1 and out_ready=1. On a transfer, shift one position toward the output end, fill with 0, and decrement the counter.
  - When out_ready=0: shift register, counter and sout hold (stall). There is no stall limit.
  - Transfer while counter==0: go to IDLE and drive done=1 for exactly the next cycle.
- Latency: the first bit is valid the cycle after acceptance. A word with no stalls takes WIDTH cycles in SHIFT. Minimum spacing between accepted words is WIDTH+1 cycles.
- No back-to-back load: in_valid during SHIFT is ignored, and upstream must hold d stable until in_ready=1.
- clear=1 (synchronous):
  - Forces IDLE, counter=0, shift register=0, done=0.
  - Has priority over load and transfer in the same cycle.
  - clear=1 together with in_valid=1 in IDLE: the word is not captured.
- reset asserted mid-word: outputs take their reset values immediately, with no done pulse. After reset deasserts, operation resumes from IDLE.
- Counter width is $clog2(WIDTH). Counter arithmetic is unsigned and never wraps, because the state leaves SHIFT at 0.
- done and in_ready can both be 1 in the same cycle. A new word may be accepted in the done cycle.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=1'b0, SHIFT=1'b1.
  - function that computes the counter width from WIDTH.
- One natural sub-module: piso_shift_reg.
  - WIDTH-bit register with parallel load, shift enable, synchronous clear and async active-low reset.
  - Built from the team's loadable flip-flop cell.
  - Direction is set by MSB_FIRST.
- The FSM and counter live in piso_serializer.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then check in_ready=1, busy=0, sout_valid=0, done=0. Assert reset mid-operation and check all outputs go to reset values before the next edge.
- MSB-first word: WIDTH=8, d=8'hA5, out_ready=1 throughout. Expect sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then done=1 for one cycle and in_ready=1.
- Stall: d=8'hC3, drop out_ready to 0 for 3 cycles after the 2nd bit. Expect sout stays 0 and busy=1 during the stall, then the remaining bits 0,0,0,0,1,1 follow, for a total of 11 SHIFT cycles.
- Ignored load plus back-to-back: during SHIFT drive in_valid=1 with d=8'hFF and expect no effect. Present 8'h0F in the done cycle and expect immediate acceptance, with bits 0,0,0,0,1,1,1,1 following.
- clear mid-word: after 3 of 8 bits of 8'hA5, pulse clear=1 together with in_valid=1. Expect IDLE next cycle, no done pulse, no capture, in_ready=1.
- LSB-first: MSB_FIRST=0, d=8'h01. Expect sout = 1,0,0,0,0,0,0,0, then done=1.
